// File: rtl/latch_driver.sv
// rtl/latch_driver.sv - serializes a word onto a latch d/le pair with setup/strobe/hold timing
// Optional even-parity slot after the MSB is enabled with LATCH_DRIVER_PARITY_EN.
module latch_driver #(
    parameter int WIDTH      = 8,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             d_out,
    output logic             le_out,
    output logic             clr_out,
    output logic             busy,
    output logic             done
);

`ifdef LATCH_DRIVER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int BW = $clog2(WIDTH + 2);

    localparam logic [3:0]    SETUP_LAST  = 4'(SETUP_CYC - 1);
    localparam logic [3:0]    STROBE_LAST = 4'(STROBE_CYC - 1);
    localparam logic [3:0]    HOLD_LAST   = 4'(HOLD_CYC - 1);
    localparam logic [BW-1:0] BIT_LAST    = BW'(NBITS - 1);
    localparam logic [BW-1:0] BIT_ONE     = BW'(1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [NBITS-1:0] sr_q, sr_d;
    logic [3:0]       cyc_q, cyc_d;
    logic [BW-1:0]    bit_q, bit_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cyc_q   <= '0;
            bit_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        in_ready = 1'b0;
        d_out    = 1'b0;
        le_out   = 1'b0;
        clr_out  = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
`ifdef LATCH_DRIVER_PARITY_EN
                    sr_d = {^in_data, in_data};
`else
                    sr_d = in_data;
`endif
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                clr_out = 1'b1;
                cyc_d   = '0;
                state_d = SETUP;
            end
            SETUP: begin
                d_out = sr_q[0];
                if (cyc_q == SETUP_LAST) begin
                    cyc_d   = '0;
                    state_d = STROBE;
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            STROBE: begin
                d_out  = sr_q[0];
                le_out = 1'b1;
                if (cyc_q == STROBE_LAST) begin
                    cyc_d   = '0;
                    state_d = HOLD;
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            HOLD: begin
                d_out = sr_q[0];
                if (cyc_q == HOLD_LAST) begin
                    cyc_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = DONE;
                    end else begin
                        // Shifting here is what moves d_out, so it only ever changes on entry to SETUP.
                        sr_d    = sr_q >> 1;
                        bit_d   = bit_q + BIT_ONE;
                        state_d = SETUP;
                    end
                end else begin
                    cyc_d = cyc_q + 4'd1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_latch_driver.sv
// tb/tb_latch_driver.sv - checks three latch_driver configurations against a slot-timing model
module tb_latch_driver;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;

    always #5 clock = ~clock;

`ifdef LATCH_DRIVER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int W  [3] = '{8, 1, 5};
    localparam int SU [3] = '{1, 1, 3};
    localparam int ST [3] = '{2, 1, 1};
    localparam int HO [3] = '{1, 1, 2};
    localparam int EXP_DONE = (PAR != 0) ? 37 : 33;

    wire [2:0] rdy, dq, le, clr, bsy, dn;

    latch_driver u0 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
        .d_out(dq[0]), .le_out(le[0]), .clr_out(clr[0]), .busy(bsy[0]), .done(dn[0])
    );
    latch_driver #(.WIDTH(1), .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) u1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data[0:0]),
        .d_out(dq[1]), .le_out(le[1]), .clr_out(clr[1]), .busy(bsy[1]), .done(dn[1])
    );
    latch_driver #(.WIDTH(5), .SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) u2 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy[2]), .in_data(in_data[4:0]),
        .d_out(dq[2]), .le_out(le[2]), .clr_out(clr[2]), .busy(bsy[2]), .done(dn[2])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected {in_ready, d_out, le_out, clr_out, busy, done} for frame cycle t
    // (t=0 is the cycle right after the accept edge).
    function automatic logic [5:0] model_out(input bit idle, input int t, input logic [32:0] bits,
                                             input int nb, input int su, input int st, input int ho);
        int s, k, p;
        s = su + st + ho;
        if (idle) return 6'b100000;
        if (t == 0) return 6'b000110;
        if (t <= nb * s) begin
            k = (t - 1) / s;
            p = (t - 1) % s;
            return {1'b0, bits[k], (p >= su && p < su + st), 1'b0, 1'b1, 1'b0};
        end
        return 6'b000011;
    endfunction

    function automatic logic [32:0] compose(input logic [7:0] data, input int w);
        logic [32:0] b;
        logic        par;
        b   = '0;
        par = 1'b0;
        for (int j = 0; j < w; j++) begin
            b[j] = data[j];
            par  = par ^ data[j];
        end
        if (PAR != 0) b[w] = par;
        return b;
    endfunction

    function automatic int frame_len(input int i);
        return 1 + (W[i] + PAR) * (SU[i] + ST[i] + HO[i]);
    endfunction

    bit          idle_m [3] = '{1'b1, 1'b1, 1'b1};
    int          t_m    [3] = '{0, 0, 0};
    logic [32:0] bits_m [3];

    always @(posedge clock or negedge reset) begin
        for (int i = 0; i < 3; i++) begin
            if (!reset) begin
                idle_m[i] <= 1'b1;
                t_m[i]    <= 0;
            end else if (idle_m[i]) begin
                if (in_valid) begin
                    idle_m[i] <= 1'b0;
                    t_m[i]    <= 0;
                    bits_m[i] <= compose(in_data, W[i]);
                end
            end else if (t_m[i] == frame_len(i)) begin
                idle_m[i] <= 1'b1;
            end else begin
                t_m[i] <= t_m[i] + 1;
            end
        end
    end

    logic le_prev [3] = '{1'b0, 1'b0, 1'b0};
    logic d_prev  [3] = '{1'b0, 1'b0, 1'b0};

    always @(negedge clock) begin
        for (int i = 0; i < 3; i++) begin
            check($sformatf("outputs_u%0d", i), {26'd0, rdy[i], dq[i], le[i], clr[i], bsy[i], dn[i]},
                  {26'd0, model_out(idle_m[i], t_m[i], bits_m[i], W[i] + PAR, SU[i], ST[i], HO[i])});
            check($sformatf("le_clr_overlap_u%0d", i), {31'd0, le[i] & clr[i]}, 32'd0);
            if (le[i] && le_prev[i]) check($sformatf("d_stable_in_strobe_u%0d", i), {31'd0, dq[i]}, {31'd0, d_prev[i]});
            le_prev[i] <= le[i];
            d_prev[i]  <= dq[i];
        end
    end

    // Runs one frame on u0 with its default timing; inputs are already presented.
    task automatic frame_check(input logic [7:0] exp_data, input logic next_v, input logic [7:0] next_d);
        logic [8:0] cap;
        int done_at, ready_at, le_cnt;
        cap = '0; done_at = -1; ready_at = -1; le_cnt = 0;
        @(posedge clock);
        #1;
        in_valid = next_v;
        in_data  = next_d;
        for (int e = 0; e < 60; e++) begin
            @(negedge clock);
            if (e == 0) check("clr_after_accept", {31'd0, clr[0]}, 32'd1);
            if (e >= 1 && (e - 1) % 4 == 0 && (e - 1) / 4 < 9) cap[(e - 1) / 4] = dq[0];
            le_cnt += int'(le[0]);
            if (dn[0] && done_at < 0) done_at = e;
            if (rdy[0] && done_at >= 0) begin
                ready_at = e;
                break;
            end
        end
        check("serial_bits", {24'd0, cap[7:0]}, {24'd0, exp_data});
        if (PAR != 0) check("parity_bit", {31'd0, cap[8]}, {31'd0, ^exp_data});
        check("done_latency", done_at, EXP_DONE);
        check("ready_again", ready_at, EXP_DONE + 1);
        check("strobe_cycles", le_cnt, 2 * (8 + PAR));
    endtask

    initial begin
        int done_cnt;
        check("pin_idle", {26'd0, model_out(1'b1, 0, 33'h0, 8, 1, 2, 1)}, 32'h20);
        check("pin_clear", {26'd0, model_out(1'b0, 0, 33'h0A5, 8, 1, 2, 1)}, 32'h06);
        check("pin_strobe", {26'd0, model_out(1'b0, 3, 33'h0A5, 8, 1, 2, 1)}, 32'h1A);
        check("pin_hold_msb", {26'd0, model_out(1'b0, 32, 33'h0A5, 8, 1, 2, 1)}, 32'h12);
        check("pin_done", {26'd0, model_out(1'b0, 33, 33'h0A5, 8, 1, 2, 1)}, 32'h03);
        check("pin_w1_strobe", {26'd0, model_out(1'b0, 2, 33'h1, 1, 1, 1, 1)}, 32'h1A);
        check("pin_w1_done", {26'd0, model_out(1'b0, 4, 33'h1, 1, 1, 1, 1)}, 32'h03);

        repeat (3) @(negedge clock);
        #1;
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        frame_check(8'hA5, 1'b1, 8'h3C);
        frame_check(8'h3C, 1'b0, 8'h00);

        #1;
        in_valid = 1'b1;
        in_data  = 8'hC3;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        check("pre_reset_strobe", {31'd0, le[0]}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_outputs", {26'd0, rdy[0], dq[0], le[0], clr[0], bsy[0], dn[0]}, 32'h20);
        @(negedge clock);
        #1;
        reset    = 1'b1;
        done_cnt = 0;
        repeat (45) begin
            @(negedge clock);
            done_cnt += int'(dn[0]);
        end
        check("no_done_after_abort", done_cnt, 0);

        #1;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        frame_check(8'h5A, 1'b0, 8'h00);
        #1;
        in_valid = 1'b1;
        in_data  = 8'h07;
        frame_check(8'h07, 1'b0, 8'h00);

        repeat (800) begin
            @(negedge clock);
            #1;
            in_valid = ($urandom_range(0, 2) == 0);
            in_data  = 8'($urandom);
            reset    = ($urandom_range(0, 149) != 0);
        end
        @(negedge clock);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (60) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
